// File: rtl/parking_pkg.sv
// Shared types, defaults and helpers for the multi-lane parking-lot occupancy controller.
package parking_pkg;

    localparam int DEF_NUM_LANES  = 2;
    localparam int DEF_DIGITS     = 2;
    localparam int DEF_CAPACITY   = 25;
    localparam int OCC_W          = $clog2(DEF_CAPACITY + 1);
    localparam int BCD_MAX_DIGITS = 4;
    localparam int BIN_MAX_W      = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EN_A,
        ST_EN_AB,
        ST_EN_B,
        ST_EX_B,
        ST_EX_BA,
        ST_EX_A,
        ST_ERR
    } lane_state_t;

    // Sensor level {a,b} that keeps a lane in the given state.
    function automatic logic [1:0] state_level(input lane_state_t s);
        logic [1:0] lvl;
        case (s)
            ST_EN_A, ST_EX_A:   lvl = 2'b10;
            ST_EN_AB, ST_EX_BA: lvl = 2'b11;
            ST_EN_B, ST_EX_B:   lvl = 2'b01;
            default:            lvl = 2'b00;
        endcase
        return lvl;
    endfunction

    // A legal step changes at most one sensor at a time.
    function automatic logic is_legal_step(input logic [1:0] level, input logic [1:0] sample);
        return (level ^ sample) != 2'b11;
    endfunction

    function automatic logic [4*BCD_MAX_DIGITS-1:0] bin2bcd(
        input logic [BIN_MAX_W-1:0] value,
        input int                   digits
    );
        logic [4*BCD_MAX_DIGITS+BIN_MAX_W-1:0] sh;
        sh = '0;
        sh[BIN_MAX_W-1:0] = value;
        for (int i = 0; i < BIN_MAX_W; i++) begin
            for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
                if (sh[BIN_MAX_W+4*d +: 4] >= 4'd5)
                    sh[BIN_MAX_W+4*d +: 4] = sh[BIN_MAX_W+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
            if (d >= digits)
                sh[BIN_MAX_W+4*d +: 4] = 4'd0;
        end
        return sh[BIN_MAX_W +: 4*BCD_MAX_DIGITS];
    endfunction

endpackage

// File: rtl/parking_lot_ctrl_lane.sv
// One gate: decodes the outer/inner sensor pair into registered entry, exit and error pulses.
module lane_detector
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic car_in,
    output logic car_out,
    output logic seq_err
);

    lane_state_t r_state;
    lane_state_t w_state_next;
    logic [1:0]  w_sample;
    logic [1:0]  w_level;
    logic        w_car_in_next;
    logic        w_car_out_next;
    logic        w_seq_err_next;
    logic        r_car_in;
    logic        r_car_out;
    logic        r_seq_err;

    always_comb begin
        w_state_next   = r_state;
        w_car_in_next  = 1'b0;
        w_car_out_next = 1'b0;
        w_seq_err_next = 1'b0;
        w_sample       = {a, b};
        w_level        = state_level(r_state);

        if (r_state == ST_ERR) begin
            if (w_sample == 2'b00)
                w_state_next = ST_IDLE;
        end else if (!is_legal_step(w_level, w_sample)) begin
            w_state_next   = ST_ERR;
            w_seq_err_next = 1'b1;
        end else if (w_sample != w_level) begin
            // Exactly one sensor changed: pick forward or reverse neighbour.
            case (r_state)
                ST_IDLE:  w_state_next = (w_sample == 2'b10) ? ST_EN_A : ST_EX_B;
                ST_EN_A:  w_state_next = (w_sample == 2'b11) ? ST_EN_AB : ST_IDLE;
                ST_EN_AB: w_state_next = (w_sample == 2'b10) ? ST_EN_A : ST_EN_B;
                ST_EN_B: begin
                    if (w_sample == 2'b11) begin
                        w_state_next = ST_EN_AB;
                    end else begin
                        w_state_next  = ST_IDLE;
                        w_car_in_next = 1'b1;
                    end
                end
                ST_EX_B:  w_state_next = (w_sample == 2'b11) ? ST_EX_BA : ST_IDLE;
                ST_EX_BA: w_state_next = (w_sample == 2'b01) ? ST_EX_B : ST_EX_A;
                ST_EX_A: begin
                    if (w_sample == 2'b11) begin
                        w_state_next = ST_EX_BA;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_car_out_next = 1'b1;
                    end
                end
                default:  w_state_next = ST_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_car_in  <= 1'b0;
            r_car_out <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_car_in  <= w_car_in_next;
            r_car_out <= w_car_out_next;
            r_seq_err <= w_seq_err_next;
        end
    end

    assign car_in  = r_car_in;
    assign car_out = r_car_out;
    assign seq_err = r_seq_err;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-lane occupancy controller: per-lane detectors, merged saturating count, BCD/status output stage.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DIGITS    = DEF_DIGITS,
    parameter int CAPACITY  = DEF_CAPACITY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LANES-1:0]  sens_a,
    input  logic [NUM_LANES-1:0]  sens_b,
    output logic [NUM_LANES-1:0]  car_in,
    output logic [NUM_LANES-1:0]  car_out,
    output logic [NUM_LANES-1:0]  seq_err,
    output logic                  limit_err,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  full,
    output logic                  empty
);

    localparam int W_OCC = $clog2(CAPACITY + 1);
    localparam int W_BCD = 4 * DIGITS;

    logic [NUM_LANES-1:0] w_car_in;
    logic [NUM_LANES-1:0] w_car_out;
    logic [NUM_LANES-1:0] w_seq_err;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            lane_detector u_lane (
                .clk     (clk),
                .reset   (reset),
                .a       (sens_a[gi]),
                .b       (sens_b[gi]),
                .car_in  (w_car_in[gi]),
                .car_out (w_car_out[gi]),
                .seq_err (w_seq_err[gi])
            );
        end
    endgenerate

    logic [W_OCC-1:0] r_occ;
    logic [W_OCC-1:0] w_occ_next;
    logic             w_clamp;
    logic             r_clamp;
    logic             r_limit_err;
    logic [W_BCD-1:0] r_count_bcd;
    logic             r_full;
    logic             r_empty;
    int               w_in_cnt;
    int               w_out_cnt;
    int               w_sum;

    // Net all lane events of this cycle, then apply a single clamp.
    always_comb begin
        w_in_cnt  = 0;
        w_out_cnt = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_in_cnt  = w_in_cnt + (w_car_in[i] ? 1 : 0);
            w_out_cnt = w_out_cnt + (w_car_out[i] ? 1 : 0);
        end
        w_sum      = int'(r_occ) + w_in_cnt - w_out_cnt;
        w_clamp    = 1'b0;
        w_occ_next = W_OCC'(w_sum);
        if (w_sum < 0) begin
            w_occ_next = '0;
            w_clamp    = 1'b1;
        end else if (w_sum > CAPACITY) begin
            w_occ_next = W_OCC'(CAPACITY);
            w_clamp    = 1'b1;
        end
    end

    // limit_err is delayed one stage so it lines up with the displayed count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ       <= '0;
            r_clamp     <= 1'b0;
            r_limit_err <= 1'b0;
            r_count_bcd <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_occ       <= w_occ_next;
            r_clamp     <= w_clamp;
            r_limit_err <= r_clamp;
            r_count_bcd <= W_BCD'(bin2bcd(BIN_MAX_W'(r_occ), DIGITS));
            r_full      <= (r_occ == W_OCC'(CAPACITY));
            r_empty     <= (r_occ == '0);
        end
    end

    assign car_in    = w_car_in;
    assign car_out   = w_car_out;
    assign seq_err   = w_seq_err;
    assign limit_err = r_limit_err;
    assign count_bcd = r_count_bcd;
    assign full      = r_full;
    assign empty     = r_empty;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl: per-cycle vector table plus hand-written multi-cycle scenarios.
module tb_parking_lot_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sens_a = 2'b00;
    logic [1:0] sens_b = 2'b00;
    logic [1:0] car_in;
    logic [1:0] car_out;
    logic [1:0] seq_err;
    logic       limit_err;
    logic [7:0] count_bcd;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;
    int lim_cnt = 0;
    int ci_cnt = 0;

    parking_lot_ctrl #(.NUM_LANES(2), .DIGITS(2), .CAPACITY(25)) dut (
        .clk       (clk),
        .reset     (reset),
        .sens_a    (sens_a),
        .sens_b    (sens_b),
        .car_in    (car_in),
        .car_out   (car_out),
        .seq_err   (seq_err),
        .limit_err (limit_err),
        .count_bcd (count_bcd),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (limit_err) lim_cnt = lim_cnt + 1;
        ci_cnt = ci_cnt + int'(car_in[0]) + int'(car_in[1]);
    end

    typedef struct packed {
        logic       rst;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] ci;
        logic [1:0] co;
        logic [1:0] se;
        logic       lim;
        logic [7:0] bcd;
        logic       full;
        logic       empty;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] ci, input logic [1:0] co, input logic [1:0] se,
                                input logic lim, input logic [7:0] bcd, input logic f, input logic e);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.ci = ci; v.co = co; v.se = se;
        v.lim = lim; v.bcd = bcd; v.full = f; v.empty = e;
        return v;
    endfunction

    task automatic step(input logic [1:0] a, input logic [1:0] b);
        sens_a = a;
        sens_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic entry(input int lane);
        logic [1:0] m;
        m = 2'b01 << lane;
        step(m, 2'b00); step(m, m); step(2'b00, m); step(2'b00, 2'b00);
    endtask

    task automatic leave(input int lane);
        logic [1:0] m;
        m = 2'b01 << lane;
        step(2'b00, m); step(m, m); step(m, 2'b00); step(2'b00, 2'b00);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'b00, 2'b00);
        reset = 1'b0;
    endtask

    logic [16:0] act_v;
    logic [16:0] exp_v;
    int          lim0;
    int          ci0;

    initial begin
        //             rst   a      b      ci     co     se    lim   bcd   full  empty
        tbl[ 0] = mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 1] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 2] = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 3] = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 4] = mk(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 5] = mk(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 6] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[ 7] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[ 8] = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[ 9] = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[21] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[22] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[23] = mk(1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[24] = mk(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[25] = mk(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[26] = mk(1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[27] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[28] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[29] = mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[30] = mk(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[31] = mk(1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[32] = mk(1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[33] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[34] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h03, 1'b0, 1'b0);
        tbl[35] = mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h03, 1'b0, 1'b0);
        tbl[36] = mk(1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 8'h03, 1'b0, 1'b0);
        tbl[37] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h03, 1'b0, 1'b0);

        #2;
        for (int i = 0; i < NV; i++) begin
            reset = tbl[i].rst;
            step(tbl[i].a, tbl[i].b);
            act_v = {car_in, car_out, seq_err, limit_err, count_bcd, full, empty};
            exp_v = {tbl[i].ci, tbl[i].co, tbl[i].se, tbl[i].lim, tbl[i].bcd, tbl[i].full, tbl[i].empty};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL row%0d {ci,co,se,lim,bcd,full,empty} actual=%05h expected=%05h", i, act_v, exp_v);
            end else begin
                $display("row %0d a=%b b=%b ci=%b co=%b se=%b lim=%b bcd=%h full=%b empty=%b ok",
                         i, tbl[i].a, tbl[i].b, car_in, car_out, seq_err, limit_err, count_bcd, full, empty);
            end
        end
        reset = 1'b0;

        // Fill to capacity: the 26th entry is clamped and flagged once.
        do_reset();
        lim0 = lim_cnt;
        for (int n = 0; n < 26; n++) entry(0);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("cap_bcd", 32'(count_bcd), 32'h25);
        check("cap_full", 32'(full), 32'h1);
        check("cap_empty", 32'(empty), 32'h0);
        step(2'b00, 2'b00);
        check("cap_limit_pulses", 32'(lim_cnt - lim0), 32'h1);
        leave(1);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("cap_exit_bcd", 32'(count_bcd), 32'h24);
        check("cap_exit_full", 32'(full), 32'h0);
        check("cap_exit_limit_pulses", 32'(lim_cnt - lim0), 32'h1);

        // Exit while empty: pulse still issued, count clamped at zero.
        do_reset();
        leave(1);
        check("empty_exit_car_out", 32'(car_out), 32'h2);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("empty_exit_limit_err", 32'(limit_err), 32'h1);
        check("empty_exit_bcd", 32'(count_bcd), 32'h00);
        check("empty_exit_empty", 32'(empty), 32'h1);
        step(2'b00, 2'b00);
        check("empty_exit_limit_done", 32'(limit_err), 32'h0);

        // Reset mid-sequence at occupancy 7.
        do_reset();
        for (int n = 0; n < 7; n++) entry(0);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("occ7_bcd", 32'(count_bcd), 32'h07);
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        ci0 = ci_cnt;
        reset = 1'b1;
        step(2'b01, 2'b01);
        reset = 1'b0;
        check("rst_mid_bcd", 32'(count_bcd), 32'h00);
        check("rst_mid_empty", 32'(empty), 32'h1);
        step(2'b01, 2'b01);
        step(2'b00, 2'b01);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("rst_mid_no_car_in", 32'(ci_cnt - ci0), 32'h0);
        check("rst_mid_bcd_after", 32'(count_bcd), 32'h00);

        // A pulse in flight when reset hits is dropped.
        entry(0);
        reset = 1'b1;
        step(2'b00, 2'b00);
        reset = 1'b0;
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("rst_pipe_bcd", 32'(count_bcd), 32'h00);
        entry(0);
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);
        check("post_rst_entry_bcd", 32'(count_bcd), 32'h01);
        check("post_rst_entry_empty", 32'(empty), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
